// File: rtl/stc0_cmd_ctrl.sv
// stc0_cmd_ctrl: byte-stream opcode parser driving the LFSR config register file
// and returning read responses through a small egress FIFO.
module stc0_cmd_ctrl #(
  parameter int         FIFO_DEPTH = 4,
  parameter int         TIMEOUT    = 255,
  parameter logic [7:0] RESP_HDR   = 8'hDE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ingress,
  input  logic       ingress_valid,
  output logic [7:0] egress,
  output logic       egress_valid,
  output logic       lfsr0_en,
  output logic       lfsr1_en,
  output logic [7:0] lfsr0_seed,
  output logic [7:0] lfsr1_seed,
  output logic [7:0] lfsr0_taps,
  output logic [7:0] lfsr1_taps,
  output logic       seed_load
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WDATA} state_t;

  state_t        state_q, state_d;
  logic [3:0]    addr_q, addr_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [7:0]    regs_q [16];
  logic [7:0]    regs_d [16];
  logic [3:0]    err_q, err_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   lvl_q, lvl_d;
  logic [7:0]    egress_q, egress_d;
  logic          egress_valid_q, egress_valid_d;
  logic          seed_load_q, seed_load_d;
  logic [3:0]    op, a;
  logic [7:0]    rd_val;
  logic          push, pop, err_ev, clr;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    regs_d      = regs_q;
    mem_d       = mem_q;
    seed_load_d = 1'b0;
    push        = 1'b0;
    err_ev      = 1'b0;
    clr         = 1'b0;
    op          = ingress[7:4];
    a           = ingress[3:0];
    pop         = lvl_q != '0;
    rd_val      = (a == 4'hF) ? {err_q, 1'b0, 3'(lvl_q)} : regs_q[a];
    if (state_q == IDLE && ingress_valid) begin
      if (op == 4'hA) begin
        state_d = WDATA;
        addr_d  = a;
        cnt_d   = '0;
      end else if (op == 4'hB) begin
        // free space judged before this cycle's pop, so a full-ish FIFO drops the read
        push   = lvl_q <= (AW+1)'(FIFO_DEPTH - 2);
        err_ev = !push;
      end else begin
        err_ev = op != 4'h0;
      end
    end else if (state_q == WDATA) begin
      if (ingress_valid) begin
        state_d = IDLE;
        if (addr_q == 4'h0) begin
          regs_d[0]   = {6'b0, ingress[1:0]};
          seed_load_d = ingress[7];
        end else if (addr_q == 4'hF) begin
          clr = 1'b1;
        end else begin
          regs_d[addr_q] = ingress;
        end
      end else if (cnt_q == TW'(TIMEOUT - 1)) begin
        state_d = IDLE;
        err_ev  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    err_d = clr ? 4'h0 : (err_ev && err_q != 4'hF) ? err_q + 4'h1 : err_q;
    if (push) begin
      mem_d[wp_q]           = RESP_HDR;
      mem_d[wp_q + AW'(1)]  = rd_val;
    end
    wp_d           = push ? wp_q + AW'(2) : wp_q;
    rp_d           = pop ? rp_q + AW'(1) : rp_q;
    lvl_d          = lvl_q + (push ? (AW+1)'(2) : (AW+1)'(0)) - (pop ? (AW+1)'(1) : (AW+1)'(0));
    egress_d       = pop ? mem_q[rp_q] : egress_q;
    egress_valid_d = pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      cnt_q          <= '0;
      err_q          <= '0;
      wp_q           <= '0;
      rp_q           <= '0;
      lvl_q          <= '0;
      egress_q       <= '0;
      egress_valid_q <= 1'b0;
      seed_load_q    <= 1'b0;
      for (int i = 0; i < 16; i++)
        regs_q[i] <= (i == 1 || i == 2) ? 8'h01 : (i == 3 || i == 4) ? 8'hB8 : 8'h00;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      cnt_q          <= cnt_d;
      err_q          <= err_d;
      wp_q           <= wp_d;
      rp_q           <= rp_d;
      lvl_q          <= lvl_d;
      egress_q       <= egress_d;
      egress_valid_q <= egress_valid_d;
      seed_load_q    <= seed_load_d;
      regs_q         <= regs_d;
      mem_q          <= mem_d;
    end
  end

  assign egress       = egress_q;
  assign egress_valid = egress_valid_q;
  assign seed_load    = seed_load_q;
  assign lfsr0_en     = regs_q[0][0];
  assign lfsr1_en     = regs_q[0][1];
  assign lfsr0_seed   = regs_q[1];
  assign lfsr1_seed   = regs_q[2];
  assign lfsr0_taps   = regs_q[3];
  assign lfsr1_taps   = regs_q[4];
endmodule

// File: tb/tb_stc0_cmd_ctrl.sv
// tb_stc0_cmd_ctrl: scoreboard bench; each read queues its expected egress bytes
// with the edge they must appear after, the monitor pops and compares them.
module tb_stc0_cmd_ctrl;
  localparam logic [7:0] HDR = 8'hDE;

  logic       clk, rst_n, ingress_valid;
  logic [7:0] ingress;
  logic [7:0] egress, lfsr0_seed, lfsr1_seed, lfsr0_taps, lfsr1_taps;
  logic       egress_valid, lfsr0_en, lfsr1_en, seed_load;

  stc0_cmd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ingress(ingress), .ingress_valid(ingress_valid),
    .egress(egress), .egress_valid(egress_valid),
    .lfsr0_en(lfsr0_en), .lfsr1_en(lfsr1_en),
    .lfsr0_seed(lfsr0_seed), .lfsr1_seed(lfsr1_seed),
    .lfsr0_taps(lfsr0_taps), .lfsr1_taps(lfsr1_taps),
    .seed_load(seed_load)
  );

  typedef struct {logic [7:0] d; int e;} exp_t;
  exp_t       sb[$];
  int         n_vec = 0, n_err = 0, cyc = 0, n_edge = 0, last_e = 0;
  logic [7:0] last_eg = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (!rst_n) last_eg = 8'h00;
    else if (egress_valid) begin
      if (sb.size() == 0) chk("spurious_valid", 32'(egress_valid), 0);
      else begin
        x = sb.pop_front();
        chk("egress", 32'(egress), 32'(x.d));
        chk("egress_cyc", cyc, x.e);
      end
      last_eg = egress;
    end else chk("egress_hold", 32'(egress), 32'(last_eg));
  end

  task automatic step(input logic v, input logic [7:0] b);
    ingress_valid = v;
    ingress       = b;
    n_edge        = cyc + 1;
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    step(1'b1, {4'hA, a});
    step(1'b1, d);
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] d);
    int h;
    ingress_valid = 1'b1;
    ingress       = {4'hB, a};
    n_edge        = cyc + 1;
    h             = (n_edge + 1 > last_e + 1) ? n_edge + 1 : last_e + 1;
    sb.push_back('{HDR, h});
    sb.push_back('{d, h + 1});
    last_e = h + 1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic drain();
    ingress_valid = 1'b0;
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("drain", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ingress_valid = 1'b0; ingress = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_seed0", 32'(lfsr0_seed), 32'h01);
    chk("rst_seed1", 32'(lfsr1_seed), 32'h01);
    chk("rst_taps0", 32'(lfsr0_taps), 32'hB8);
    chk("rst_taps1", 32'(lfsr1_taps), 32'hB8);
    chk("rst_en", {30'b0, lfsr1_en, lfsr0_en}, 0);
    chk("rst_evalid", 32'(egress_valid), 0);
    chk("rst_egress", 32'(egress), 0);
    chk("rst_sload", 32'(seed_load), 0);
    rd(4'h3, 8'hB8); drain();

    wr(4'h1, 8'h5A);
    chk("seed0_wr", 32'(lfsr0_seed), 32'h5A);
    rd(4'h1, 8'h5A); drain();
    wr(4'h4, 8'h1D);
    chk("taps1_wr", 32'(lfsr1_taps), 32'h1D);

    wr(4'h0, 8'h83);
    chk("sload_pulse", 32'(seed_load), 1);
    chk("en_set", {30'b0, lfsr1_en, lfsr0_en}, 3);
    idle(1);
    chk("sload_end", 32'(seed_load), 0);
    rd(4'h0, 8'h03); drain();

    step(1'b1, 8'h37);
    rd(4'hF, 8'h10); drain();
    wr(4'hF, 8'h00);
    rd(4'hF, 8'h00); drain();

    step(1'b1, 8'hA5);
    idle(255);
    rd(4'h5, 8'h00); drain();
    rd(4'hF, 8'h10); drain();

    rd(4'h1, 8'h5A);
    rd(4'h2, 8'h01);
    step(1'b1, 8'hB3);
    drain();
    rd(4'h3, 8'hB8);
    rd(4'hF, 8'h22); drain();

    step(1'b1, 8'hA6);
    idle(254);
    step(1'b1, 8'h77);
    rd(4'h6, 8'h77); drain();
    rd(4'hF, 8'h20); drain();

    wr(4'h1, 8'h33);
    step(1'b1, 8'hA7);
    ingress_valid = 1'b0;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_seed0", 32'(lfsr0_seed), 32'h01);
    chk("mid_rst_en", {30'b0, lfsr1_en, lfsr0_en}, 0);
    step(1'b1, 8'h07);
    rd(4'h7, 8'h00);
    rd(4'h1, 8'h01); drain();
    rd(4'hF, 8'h00); drain();

    repeat (17) step(1'b1, 8'hC0);
    rd(4'hF, 8'hF0); drain();
    wr(4'hF, 8'h00);
    rd(4'hF, 8'h00); drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
